// File: rtl/vdcm_rc_pkg.sv
// Shared rate-control constants and helpers: QP limits, minQp by
// bits-per-component, zone base deltas and panic threshold shift.
package vdcm_rc_pkg;

    localparam logic signed [8:0] MAX_QP      = 9'sd72;
    localparam int                PANIC_SHIFT = 4;
    localparam logic signed [3:0] PANIC_DELTA = 4'sd4;

    typedef enum logic [1:0] {
        RC_IDLE = 2'd0,
        RC_FULL = 2'd1,
        RC_QP   = 2'd2
    } rc_state_e;

    // bpc code 3 shares the 12-bit entry
    function automatic logic signed [8:0] min_qp(input logic [1:0] bpc);
        logic signed [8:0] m;
        unique case (bpc)
            2'd0:    m = 9'sd16;
            2'd1:    m = 9'sd0;
            default: m = -9'sd16;
        endcase
        return m;
    endfunction

    function automatic logic signed [3:0] zone_base(input logic [1:0] zone);
        logic signed [3:0] d;
        unique case (zone)
            2'd0: d = -4'sd2;
            2'd1: d = -4'sd1;
            2'd2: d = 4'sd0;
            2'd3: d = 4'sd1;
        endcase
        return d;
    endfunction

    function automatic logic [7:0] qp_clamp(input logic signed [8:0] v,
                                            input logic [1:0] bpc);
        logic signed [8:0] lo;
        logic signed [8:0] res;
        lo = min_qp(bpc);
        if (v < lo)
            res = lo;
        else if (v > MAX_QP)
            res = MAX_QP;
        else
            res = v;
        return res[7:0];
    endfunction

endpackage

// File: rtl/rc_zone_classify.sv
// Buffer fullness zone classifier (combinational).
// Ports: i_fullness, i_buf_size in; o_zone (0..3), o_panic out.
module rc_zone_classify
    import vdcm_rc_pkg::*;
#(
    parameter int FULL_W = 16
) (
    input  logic [FULL_W-1:0] i_fullness,
    input  logic [FULL_W-1:0] i_buf_size,
    output logic [1:0]        o_zone,
    output logic              o_panic
);

    logic [FULL_W-1:0] w_q1;
    logic [FULL_W-1:0] w_q2;
    logic [FULL_W-1:0] w_q3;
    logic [FULL_W-1:0] w_pan;

    assign w_q1  = i_buf_size >> 2;
    assign w_q2  = i_buf_size >> 1;
    assign w_q3  = i_buf_size - (i_buf_size >> 2);
    assign w_pan = i_buf_size - (i_buf_size >> PANIC_SHIFT);

    always_comb begin
        o_zone = 2'd3;
        if (i_fullness < w_q1)
            o_zone = 2'd0;
        else if (i_fullness < w_q2)
            o_zone = 2'd1;
        else if (i_fullness < w_q3)
            o_zone = 2'd2;
    end

    assign o_panic = (i_fullness >= w_pan);

endmodule

// File: rtl/rc_master_qp_gen.sv
// Rate-control master QP generator: tracks buffer fullness per coded
// block and steps masterQp by zone, budget error and panic state.
// Ports: clk, rst (async high); static config bits_per_component_coded,
// target_bits, buffer_size; slice init init_fullness, init_qp,
// slice_start; block_bits/valid/ready handshake; masterQp,
// masterQp_valid, rc_fullness outputs.
module rc_master_qp_gen
    import vdcm_rc_pkg::*;
#(
    parameter int BITS_W = 12,
    parameter int FULL_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        bits_per_component_coded,
    input  logic [BITS_W-1:0] target_bits,
    input  logic [FULL_W-1:0] buffer_size,
    input  logic [FULL_W-1:0] init_fullness,
    input  logic [7:0]        init_qp,
    input  logic              slice_start,
    input  logic [BITS_W-1:0] block_bits,
    input  logic              block_bits_valid,
    output logic              block_bits_ready,
    output logic [7:0]        masterQp,
    output logic              masterQp_valid,
    output logic [FULL_W-1:0] rc_fullness
);

    localparam int SUM_W = FULL_W + 2;

    rc_state_e r_state;
    rc_state_e w_next_state;
    logic      w_accept;

    logic [BITS_W-1:0] r_bits;
    logic [FULL_W-1:0] r_full;
    logic [7:0]        r_qp;
    logic              r_valid;

    logic signed [SUM_W-1:0] w_sum;
    logic signed [SUM_W-1:0] w_bsz_ext;
    logic [FULL_W-1:0]       w_full_next;

    logic [1:0]              w_zone;
    logic                    w_panic;
    logic signed [BITS_W:0]  w_diff;
    logic signed [BITS_W:0]  w_thr;
    logic signed [3:0]       w_adj;
    logic signed [3:0]       w_delta;
    logic signed [8:0]       w_qp_sum;
    logic [7:0]              w_qp_next;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= RC_IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        if (slice_start) begin
            // slice start wins; a block offered now is dropped
            w_next_state = RC_IDLE;
        end else begin
            case (r_state)
                RC_IDLE: begin
                    if (block_bits_valid) begin
                        w_accept     = 1'b1;
                        w_next_state = RC_FULL;
                    end
                end
                RC_FULL: w_next_state = RC_QP;
                RC_QP:   w_next_state = RC_IDLE;
                default: w_next_state = RC_IDLE;
            endcase
        end
    end

    // ---------------- fullness update ----------------
    assign w_sum = $signed({2'b00, r_full})
                 + $signed({{(SUM_W-BITS_W){1'b0}}, r_bits})
                 - $signed({{(SUM_W-BITS_W){1'b0}}, target_bits});
    assign w_bsz_ext = $signed({2'b00, buffer_size});

    always_comb begin
        w_full_next = w_sum[FULL_W-1:0];
        if (w_sum < 0)
            w_full_next = '0;
        else if (w_sum > w_bsz_ext)
            w_full_next = buffer_size;
    end

    // ---------------- QP step ----------------
    // r_full already holds the updated fullness when state is QP
    rc_zone_classify #(
        .FULL_W(FULL_W)
    ) u_zone (
        .i_fullness(r_full),
        .i_buf_size(buffer_size),
        .o_zone    (w_zone),
        .o_panic   (w_panic)
    );

    assign w_diff = $signed({1'b0, r_bits}) - $signed({1'b0, target_bits});
    assign w_thr  = $signed({1'b0, target_bits >> 2});

    always_comb begin
        w_adj = 4'sd0;
        if (w_diff > w_thr)
            w_adj = 4'sd1;
        else if (w_diff < -w_thr)
            w_adj = -4'sd1;
    end

    assign w_delta   = w_panic ? PANIC_DELTA : zone_base(w_zone) + w_adj;
    assign w_qp_sum  = $signed({r_qp[7], r_qp})
                     + $signed({{5{w_delta[3]}}, w_delta});
    assign w_qp_next = qp_clamp(w_qp_sum, bits_per_component_coded);

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bits  <= '0;
            r_full  <= '0;
            r_qp    <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (slice_start) begin
                r_full  <= init_fullness;
                r_qp    <= qp_clamp($signed({init_qp[7], init_qp}),
                                    bits_per_component_coded);
                r_valid <= 1'b1;
            end else begin
                if (w_accept)
                    r_bits <= block_bits;
                if (r_state == RC_FULL)
                    r_full <= w_full_next;
                if (r_state == RC_QP) begin
                    r_qp    <= w_qp_next;
                    r_valid <= 1'b1;
                end
            end
        end
    end

    assign block_bits_ready = (r_state == RC_IDLE);
    assign masterQp         = r_qp;
    assign masterQp_valid   = r_valid;
    assign rc_fullness      = r_full;

endmodule

// File: tb/tb_rc_master_qp_gen.sv
// Self-checking bench for rc_master_qp_gen: directed table, corner
// sequences and randomized blocks against an arithmetic model.
module tb_rc_master_qp_gen;

    localparam int BITS_W = 12;
    localparam int FULL_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        bpc;
    logic [BITS_W-1:0] target_bits;
    logic [FULL_W-1:0] buffer_size;
    logic [FULL_W-1:0] init_fullness;
    logic [7:0]        init_qp;
    logic              slice_start;
    logic [BITS_W-1:0] block_bits;
    logic              block_bits_valid;
    logic              block_bits_ready;
    logic [7:0]        masterQp;
    logic              masterQp_valid;
    logic [FULL_W-1:0] rc_fullness;

    rc_master_qp_gen #(
        .BITS_W(BITS_W),
        .FULL_W(FULL_W)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .bits_per_component_coded(bpc),
        .target_bits             (target_bits),
        .buffer_size             (buffer_size),
        .init_fullness           (init_fullness),
        .init_qp                 (init_qp),
        .slice_start             (slice_start),
        .block_bits              (block_bits),
        .block_bits_valid        (block_bits_valid),
        .block_bits_ready        (block_bits_ready),
        .masterQp                (masterQp),
        .masterQp_valid          (masterQp_valid),
        .rc_fullness             (rc_fullness)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // reference model state
    int m_full;
    int m_qp;
    int m_bpc;
    int m_tgt;
    int m_buf;

    typedef struct {
        int bpc;
        int full0;
        int qp0;
        int bits;
        int exp_full;
        int exp_qp;
    } vec_t;

    vec_t tbl[4];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int qp_of_dut();
        return int'($signed(masterQp));
    endfunction

    function automatic int min_qp(input int b);
        if (b == 0) return 16;
        if (b == 1) return 0;
        return -16;
    endfunction

    function automatic int clampq(input int v, input int b);
        if (v < min_qp(b)) return min_qp(b);
        if (v > 72) return 72;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // model: one block of 'bits' spent
    task automatic model_block(input int bits, output int ef, output int eq);
        int f;
        int base;
        int adj;
        int delta;
        f = m_full + bits - m_tgt;
        if (f < 0) f = 0;
        if (f > m_buf) f = m_buf;
        if (f < m_buf / 4) base = -2;
        else if (f < m_buf / 2) base = -1;
        else if (f < m_buf - m_buf / 4) base = 0;
        else base = 1;
        adj = 0;
        if (bits - m_tgt > m_tgt / 4) adj = 1;
        else if (bits - m_tgt < -(m_tgt / 4)) adj = -1;
        if (f >= m_buf - m_buf / 16) delta = 4;
        else delta = base + adj;
        m_full = f;
        m_qp   = clampq(m_qp + delta, m_bpc);
        ef = m_full;
        eq = m_qp;
    endtask

    task automatic do_slice(input int b, input int bsz, input int tgt,
                            input int full, input int qp);
        bpc           = 2'(b);
        buffer_size   = FULL_W'(bsz);
        target_bits   = BITS_W'(tgt);
        init_fullness = FULL_W'(full);
        init_qp       = 8'(qp);
        slice_start   = 1'b1;
        tick();
        slice_start = 1'b0;
        m_bpc  = b;
        m_buf  = bsz;
        m_tgt  = tgt;
        m_full = full;
        m_qp   = clampq(qp, b);
        check("slice_qp", qp_of_dut(), m_qp);
        check("slice_valid", int'(masterQp_valid), 1);
        check("slice_full", int'(rc_fullness), full);
        check("slice_ready", int'(block_bits_ready), 1);
    endtask

    // ends just after E2; the caller or next block checks E3
    task automatic do_block(input int bits, input int ef, input int eq);
        int n;
        n = 0;
        while (!block_bits_ready && n < 10) begin
            tick();
            n++;
        end
        if (!block_bits_ready) begin
            check("ready_timeout", 0, 1);
            return;
        end
        block_bits       = BITS_W'(bits);
        block_bits_valid = 1'b1;
        tick();
        block_bits_valid = 1'b0;
        check("e0_ready", int'(block_bits_ready), 0);
        check("e0_valid", int'(masterQp_valid), 0);
        tick();
        check("e1_full", int'(rc_fullness), ef);
        check("e1_valid", int'(masterQp_valid), 0);
        tick();
        check("e2_qp", qp_of_dut(), eq);
        check("e2_valid", int'(masterQp_valid), 1);
        check("e2_ready", int'(block_bits_ready), 1);
    endtask

    task automatic count_pulses(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (masterQp_valid) cnt++;
        end
    endtask

    initial begin
        int ef;
        int eq;
        int cnt;

        tbl[0] = '{1, 512, 24, 96, 512, 24};
        tbl[1] = '{1, 512, 24, 200, 616, 25};
        tbl[2] = '{1, 1000, 70, 96, 1000, 72};
        tbl[3] = '{2, 0, -15, 0, 0, -16};

        rst              = 1'b1;
        bpc              = 2'd1;
        target_bits      = BITS_W'(96);
        buffer_size      = FULL_W'(1024);
        init_fullness    = '0;
        init_qp          = '0;
        slice_start      = 1'b0;
        block_bits       = '0;
        block_bits_valid = 1'b0;

        // reset
        #12;
        check("rst_qp", qp_of_dut(), 0);
        check("rst_valid", int'(masterQp_valid), 0);
        check("rst_full", int'(rc_fullness), 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("post_rst_ready", int'(block_bits_ready), 1);
        check("post_rst_qp", qp_of_dut(), 0);
        check("post_rst_valid", int'(masterQp_valid), 0);

        // directed table
        for (int i = 0; i < 4; i++) begin
            do_slice(tbl[i].bpc, 1024, 96, tbl[i].full0, tbl[i].qp0);
            do_block(tbl[i].bits, tbl[i].exp_full, tbl[i].exp_qp);
            tick();
            check("e3_valid_clear", int'(masterQp_valid), 0);
        end

        // collision: slice_start and block in same cycle
        do_slice(1, 1024, 96, 512, 24);
        tick();
        bpc              = 2'd1;
        init_fullness    = FULL_W'(300);
        init_qp          = 8'(30);
        block_bits       = BITS_W'(500);
        block_bits_valid = 1'b1;
        slice_start      = 1'b1;
        tick();
        slice_start      = 1'b0;
        block_bits_valid = 1'b0;
        check("coll_qp", qp_of_dut(), 30);
        check("coll_valid", int'(masterQp_valid), 1);
        check("coll_ready", int'(block_bits_ready), 1);
        count_pulses(5, cnt);
        check("coll_extra_pulses", cnt, 0);
        check("coll_full", int'(rc_fullness), 300);

        // slice_start aborting an in-flight block
        do_slice(1, 1024, 96, 512, 24);
        block_bits       = BITS_W'(400);
        block_bits_valid = 1'b1;
        tick();
        block_bits_valid = 1'b0;
        init_qp          = 8'(40);
        init_fullness    = FULL_W'(700);
        slice_start      = 1'b1;
        tick();
        slice_start = 1'b0;
        check("abort_qp", qp_of_dut(), 40);
        check("abort_valid", int'(masterQp_valid), 1);
        check("abort_ready", int'(block_bits_ready), 1);
        count_pulses(4, cnt);
        check("abort_extra_pulses", cnt, 0);
        check("abort_full", int'(rc_fullness), 700);

        // reset mid-operation
        do_slice(1, 1024, 96, 512, 24);
        block_bits       = BITS_W'(300);
        block_bits_valid = 1'b1;
        tick();
        block_bits_valid = 1'b0;
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("midrst_qp", qp_of_dut(), 0);
        check("midrst_valid", int'(masterQp_valid), 0);
        check("midrst_full", int'(rc_fullness), 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("midrst_ready", int'(block_bits_ready), 1);
        count_pulses(4, cnt);
        check("midrst_pulses", cnt, 0);

        // randomized slices, blocks back to back
        for (int s = 0; s < 8; s++) begin
            int rb;
            int rbuf;
            int rtgt;
            rb   = int'($urandom_range(0, 3));
            rbuf = int'($urandom_range(256, 65535));
            rtgt = int'($urandom_range(1, 4095));
            do_slice(rb, rbuf, rtgt, int'($urandom_range(0, rbuf)),
                     int'($urandom_range(0, 120)) - 40);
            for (int k = 0; k < 20; k++) begin
                int bits;
                if ($urandom_range(0, 1) == 0)
                    bits = int'($urandom_range(0, 4095));
                else
                    bits = clampq(rtgt + int'($urandom_range(0, 64)) - 32,
                                  1) + 0;
                if (bits > 4095) bits = 4095;
                if (bits < 0) bits = 0;
                if ($urandom_range(0, 3) == 0) tick();
                model_block(bits, ef, eq);
                do_block(bits, ef, eq);
            end
            tick();
            check("rand_e3_clear", int'(masterQp_valid), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
